data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the single data-RAM/MMIO slave port between two bus masters: m0 (core data port) and m1 (debug/loader DMA port).
- Grants one master per cycle with round-robin fairness and burst ownership capped at MAX_BURST beats.
- Drives the slave port and routes the slave's 1-cycle-latency read data back to the correct master with a valid strobe.
- Sits in the toplevel between the core/DMA and the memory map decode.

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width; mask width is DATA_W/8
MAX_BURST, 4, consecutive accepted beats the owner may take while the other master is requesting; range 1..15

Ports:
clk  in  1  system clock
async_rst  in  1  asynchronous, active-high reset
clk_en  in  1  global clock enable; all state advances only when high
m0_req  in  1  master 0 access request; held until granted
m0_we  in  1  1=write, 0=read
m0_addr  in  ADDR_W  word address
m0_mask  in  DATA_W/8  byte write enables
m0_wdata  in  DATA_W  write data
m0_gnt  out  1  beat accepted this cycle (combinational)
m0_rvalid  out  1  m0_rdata valid (read accepted previous enabled cycle)
m0_rdata  out  DATA_W  read data
m1_*  same set as m0_* for master 1
s_en  out  1  slave access strobe
s_we  out  1  slave write
s_addr  out  ADDR_W  slave address
s_mask  out  DATA_W/8  slave byte enables
s_wdata  out  DATA_W  slave write data
s_rdata  in  DATA_W  slave read data, valid 1 enabled cycle after a read strobe

Behaviour:
- Reset values (async, immediate): owner=NONE, last_served=M1 (so m0 wins the first tie), burst_cnt=0, rd_pending=0, rd_owner=M0. Outputs: m*_gnt=0, m*_rvalid=0, s_en=0, s_we=0, s_mask=0. s_addr/s_wdata/m*_rdata are don't-care.
- Owner FSM states: NONE, OWN0, OWN1.
- Grant decision (combinational, evaluated each cycle with clk_en=1):
  - NONE: single requester is granted. If both request, grant the master != last_served.
  - OWNx while mx_req=1: keep x, unless burst_cnt==MAX_BURST and the other master requests; then grant the other master this cycle.
  - OWNx while mx_req=0: grant the other master if it requests, else no grant.
- Grant effects:
  - gnt=1 for the granted master only; at most one gnt per cycle.
  - s_en=gnt_any; s_we, s_addr, s_mask and s_wdata are muxed from the granted master. s_mask is forced to 0 on reads.
- Registered on enabled edge:
  - owner <= granted id, or NONE if no grant.
  - burst_cnt <= 1 on an owner change; else saturating +1 per accepted beat; 0 when NONE.
  - last_served <= granted id.
- Read return:
  - Accepted read sets rd_pending=1 and rd_owner=id; otherwise rd_pending=0.
  - m*_rvalid = rd_pending && rd_owner==*. Latency: gnt edge to rvalid = 1 enabled cycle.
  - m0_rdata = m1_rdata = s_rdata (unqualified).
  - Writes produce no response.
- Back-to-back reads from alternating masters are allowed: rvalid follows each grant in order, with no bubble.
- clk_en=0: all gnt=0, s_en=0, and every register holds, including rvalid. A pending read is delivered on the next enabled cycle.
- A request deasserted before grant is legal; it is simply dropped.
- Reset mid-burst or with a read pending: the pending response is discarded and no rvalid is issued after reset.
- MAX_BURST=1 gives strict alternation under continuous contention.

Decomposition:
- Package srv1_bus_pkg holds:
  - owner_e enum {OWN_NONE, OWN0, OWN1}
  - master_id_e {M0, M1}
  - localparams BUS_ADDR_W=30, BUS_DATA_W=32
  - a bus_req_t struct (req, we, addr, mask, wdata) reused by future masters.
- One natural sub-module, rr_grant2: a combinational 2-way grant with owner/burst inputs. The FSM, counters and read pipeline stay in data_bus_arbiter.

Test Plan:
- Reset, then m0 alone reads 0x0010 -> m0_gnt=1 same cycle, s_en=1, s_addr=0x0010, s_mask=0; next cycle m0_rvalid=1 with m0_rdata=s_rdata; m1_rvalid=0.
- Both masters request from reset -> m0 granted first; with continuous contention and MAX_BURST=4, grant sequence is m0 x4, m1 x4, m0 x4.
- m0 writes 0xDEADBEEF mask 0b0101 to 0x0020 while m1 idle -> s_we=1, s_wdata=0xDEADBEEF, s_mask=0101; no rvalid on either master.
- Alternating reads m0@0x1, m1@0x2, m0@0x3 on successive cycles -> rvalid sequence m0, m1, m0, each one cycle after its grant.
- clk_en dropped the cycle after a granted m1 read, held low 3 cycles -> gnt=0 and s_en=0 during the low period; m1_rvalid stays at its value until the next enabled cycle, then behaves normally.
- async_rst asserted mid-burst with a read pending -> all outputs go to 0 immediately; after release, no stale rvalid; the first tie is granted to m0.

Source files
------------

// File: rtl/srv1_bus_pkg.sv
// Shared bus types for the srv1 data-side interconnect.
// Owner/master encodings and the generic request bundle.
package srv1_bus_pkg;

    localparam int BUS_ADDR_W = 30;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_MASK_W = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN0,
        OWN1
    } owner_e;

    typedef enum logic {
        M0,
        M1
    } master_id_e;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_MASK_W-1:0] mask;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic owner_e own_of(master_id_e id);
        return (id == M1) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_grant2.sv
// Two-way round-robin grant with burst ownership.
// Purely combinational; the caller qualifies with clock enable.
import srv1_bus_pkg::*;

module rr_grant2 (
    input  owner_e     owner,
    input  logic       at_max,
    input  master_id_e last_served,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1
);

    // Keep the owner until its burst is spent and the peer is waiting.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (owner)
            OWN0: begin
                if (req0 && !(at_max && req1)) gnt0 = 1'b1;
                else                           gnt1 = req1;
            end
            OWN1: begin
                if (req1 && !(at_max && req0)) gnt1 = 1'b1;
                else                           gnt0 = req0;
            end
            default: begin
                if (req0 && req1) begin
                    gnt0 = (last_served == M1);
                    gnt1 = (last_served == M0);
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Arbitrates m0 (core) and m1 (debug DMA) onto one slave port
// and steers the 1-cycle read data back to the requester.
import srv1_bus_pkg::*;

module data_bus_arbiter #(
    parameter int ADDR_W    = BUS_ADDR_W,
    parameter int DATA_W    = BUS_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                async_rst,
    input  logic                clk_en,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W/8-1:0] m0_mask,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W/8-1:0] m1_mask,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_en,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W/8-1:0] s_mask,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W-1:0]   s_rdata
);

    localparam int CNT_W = 4;

    owner_e           owner;
    master_id_e       last_served;
    master_id_e       rd_owner;
    master_id_e       gnt_id;
    logic [CNT_W-1:0] burst_cnt;
    logic             rd_pending;
    logic             at_max;
    logic             raw0;
    logic             raw1;
    logic             gnt_any;
    logic             rd_accept;

    assign at_max = (burst_cnt == CNT_W'(MAX_BURST));

    rr_grant2 u_grant (
        .owner       (owner),
        .at_max      (at_max),
        .last_served (last_served),
        .req0        (m0_req),
        .req1        (m1_req),
        .gnt0        (raw0),
        .gnt1        (raw1)
    );

    assign m0_gnt  = raw0 && clk_en && !async_rst;
    assign m1_gnt  = raw1 && clk_en && !async_rst;
    assign gnt_any = m0_gnt || m1_gnt;
    assign gnt_id  = m1_gnt ? M1 : M0;

    // Slave port follows whichever master won this cycle.
    always_comb begin
        s_en    = gnt_any;
        s_we    = m1_gnt ? m1_we    : (m0_gnt && m0_we);
        s_addr  = m1_gnt ? m1_addr  : m0_addr;
        s_wdata = m1_gnt ? m1_wdata : m0_wdata;
        s_mask  = '0;
        if (s_we) s_mask = m1_gnt ? m1_mask : m0_mask;
    end

    assign rd_accept = gnt_any && !s_we;

    // Owner FSM, burst counter and read-return pipeline.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            owner       <= OWN_NONE;
            last_served <= M1;
            burst_cnt   <= '0;
            rd_pending  <= 1'b0;
            rd_owner    <= M0;
        end else if (clk_en) begin
            if (gnt_any) begin
                if (owner != own_of(gnt_id)) burst_cnt <= CNT_W'(1);
                else if (!at_max)            burst_cnt <= burst_cnt + 1'b1;
                owner       <= own_of(gnt_id);
                last_served <= gnt_id;
            end else begin
                owner     <= OWN_NONE;
                burst_cnt <= '0;
            end
            rd_pending <= rd_accept;
            if (rd_accept) rd_owner <= gnt_id;
        end
    end

    assign m0_rvalid = rd_pending && (rd_owner == M0);
    assign m1_rvalid = rd_pending && (rd_owner == M1);
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomised bench for data_bus_arbiter against a
// transaction-level model of the arbitration rules.
module tb_data_bus_arbiter;

    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [MW-1:0] mask  [2];
    logic [DW-1:0] wdata [2];
    logic          gnt   [2];
    logic          rv    [2];
    logic [DW-1:0] rdata [2];
    logic          s_en;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [MW-1:0] s_mask;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    // model state: owner (-1 none), beats in run, last served, pending read
    int cur, run, last, pend, pend_id;
    int smp_g0, smp_g1;

    always #5 clk = ~clk;

    data_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAX)) dut (
        .clk(clk), .async_rst(rst), .clk_en(en),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]),
        .m0_mask(mask[0]), .m0_wdata(wdata[0]),
        .m0_gnt(gnt[0]), .m0_rvalid(rv[0]), .m0_rdata(rdata[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]),
        .m1_mask(mask[1]), .m1_wdata(wdata[1]),
        .m1_gnt(gnt[1]), .m1_rvalid(rv[1]), .m1_rdata(rdata[1]),
        .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_mask(s_mask),
        .s_wdata(s_wdata), .s_rdata(s_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    task automatic model_reset();
        cur = -1; run = 0; last = 1; pend = 0; pend_id = 0;
    endtask

    function automatic int winner();
        if (!en) return -1;
        if (cur < 0) begin
            if (req[0] && req[1]) return 1 - last;
            if (req[0]) return 0;
            if (req[1]) return 1;
            return -1;
        end
        if (req[cur] && !(run >= MAX && req[1-cur])) return cur;
        if (req[1-cur]) return 1 - cur;
        return -1;
    endfunction

    task automatic set_m(input int m, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [MW-1:0] k,
                         input logic [DW-1:0] d);
        req[m] = r; we[m] = w; addr[m] = a; mask[m] = k; wdata[m] = d;
    endtask

    // Called just after a falling edge with inputs settled.
    task automatic cycle();
        int w;
        #1;
        w = winner();
        smp_g0 = int'(gnt[0]);
        smp_g1 = int'(gnt[1]);
        check("m0_gnt", 32'(gnt[0]), 32'(w == 0));
        check("m1_gnt", 32'(gnt[1]), 32'(w == 1));
        check("s_en", 32'(s_en), 32'(w >= 0));
        check("m0_rvalid", 32'(rv[0]), 32'(pend && pend_id == 0));
        check("m1_rvalid", 32'(rv[1]), 32'(pend && pend_id == 1));
        if (pend) check("rdata", rdata[pend_id], s_rdata);
        if (w >= 0) begin
            check("s_we", 32'(s_we), 32'(we[w]));
            check("s_addr", 32'(s_addr), 32'(addr[w]));
            check("s_mask", 32'(s_mask), we[w] ? 32'(mask[w]) : 32'd0);
            if (we[w]) check("s_wdata", s_wdata, wdata[w]);
        end else begin
            check("s_we_idle", 32'(s_we), 32'd0);
        end
        if (en) begin
            if (w >= 0) begin
                if (w != cur) run = 1;
                else if (run < MAX) run++;
                cur = w;
                last = w;
            end else begin
                cur = -1;
                run = 0;
            end
            pend = (w >= 0 && !we[w]) ? 1 : 0;
            if (pend != 0) pend_id = w;
        end
        @(negedge clk);
        s_rdata = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_g0"}, 32'(gnt[0]), 32'd0);
        check({tag, "_g1"}, 32'(gnt[1]), 32'd0);
        check({tag, "_rv0"}, 32'(rv[0]), 32'd0);
        check({tag, "_rv1"}, 32'(rv[1]), 32'd0);
        check({tag, "_sen"}, 32'(s_en), 32'd0);
        check({tag, "_swe"}, 32'(s_we), 32'd0);
        check({tag, "_smask"}, 32'(s_mask), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        s_rdata = 32'h0;
        set_m(0, 1'b1, 1'b0, 30'h10, 4'hf, 32'h0);
        set_m(1, 1'b1, 1'b0, 30'h20, 4'hf, 32'h0);
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // continuous contention: m0 x4, m1 x4, m0 x4
        for (int i = 0; i < 12; i++) begin
            set_m(0, 1'b1, 1'b0, 30'(i), 4'h3, 32'h0);
            set_m(1, 1'b1, 1'b0, 30'(100 + i), 4'h3, 32'h0);
            cycle();
            check("burst_seq", 32'(smp_g0), 32'(((i / 4) % 2) == 0));
        end

        // idle, then m0 alone reads 0x10
        set_m(0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        cycle();
        set_m(0, 1'b1, 1'b0, 30'h10, 4'hf, 32'h0);
        cycle();
        check("rd10_gnt", 32'(smp_g0), 32'd1);
        set_m(0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        cycle();

        // m0 write with partial mask
        set_m(0, 1'b1, 1'b1, 30'h20, 4'b0101, 32'hDEADBEEF);
        cycle();
        set_m(0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        cycle();
        cycle();

        // alternating reads m0@1, m1@2, m0@3
        set_m(0, 1'b1, 1'b0, 30'h1, 4'h0, 32'h0);
        cycle();
        set_m(0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        set_m(1, 1'b1, 1'b0, 30'h2, 4'h0, 32'h0);
        cycle();
        set_m(1, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        set_m(0, 1'b1, 1'b0, 30'h3, 4'h0, 32'h0);
        cycle();
        set_m(0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        cycle();
        cycle();

        // m1 read then clk_en low for 3 cycles
        set_m(1, 1'b1, 1'b0, 30'h44, 4'h0, 32'h0);
        cycle();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_rv1", 32'(rv[1]), 32'd1);
        end
        en = 1'b1;
        set_m(1, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
        cycle();
        cycle();

        // reset mid-burst with a read pending
        set_m(0, 1'b1, 1'b0, 30'h5, 4'h0, 32'h0);
        set_m(1, 1'b1, 1'b0, 30'h6, 4'h0, 32'h0);
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("post_rst_tie", 32'(smp_g0), 32'd1);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 2; m++)
                set_m(m, 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), 30'($urandom),
                      4'($urandom), $urandom);
            en = 1'($urandom_range(0, 7) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
